// File: rtl/uart_rx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_mmio
//  Purpose  : 8N1 UART receiver with a small receive FIFO and two
//             memory-mapped read registers (status and data).
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   single clock, rising edge
//    rst      in   1   synchronous active-high reset
//    rxd      in   1   asynchronous serial line, idles high, LSB first
//    rdEn     in   1   read strobe from the core data port
//    rdAddr   in  32   read address (full 32-bit compare)
//    rdData   out 32   registered read data (0 when not addressed)
//    rxAvail  out  1   high while the receive FIFO holds at least one byte
//
//  Register map
//    BASE_ADDR     status : bit0 notEmpty, bit1 overrun, bit2 frameErr,
//                           bits[11:8] FIFO count; read clears the flags
//    BASE_ADDR+4   data   : {24'b0, head byte}; read pops the FIFO
// ============================================================================
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        rdEn,
  input  logic [31:0] rdAddr,
  output logic [31:0] rdData,
  output logic        rxAvail
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR;
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer. rxs_d is one more delayed copy of rxs, used only to
  // spot the 1->0 start edge; everything downstream sees rxs alone.
  // --------------------------------------------------------------------------
  logic sync_a;
  logic rxs;
  logic rxs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
    end else begin
      sync_a <= rxd;
      rxs    <= sync_a;
      rxs_d  <= rxs;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t        state,   state_n;
  logic [CW-1:0] cnt,     cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift,   shift_n;
  logic          push_req;
  logic          ferr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a high level means the
        // falling edge was only a glitch.
        if (cnt == CNT_MID) begin
          cnt_n = '0;
          if (!rxs) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        // Counting from mid start bit, each full bit period lands on the
        // middle of the next data bit.
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rxs, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rxs) begin
            push_req = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read decode and receive FIFO
  // --------------------------------------------------------------------------
  logic          stat_rd;
  logic          data_rd;
  logic          not_empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovr_set;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;

  assign stat_rd   = rdEn && (rdAddr == STAT_ADDR);
  assign data_rd   = rdEn && (rdAddr == DATA_ADDR);
  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = data_rd && not_empty;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // only overruns when nothing is being read out.
  assign push      = push_req && (!full || pop);
  assign ovr_set   = push_req && full && !pop;
  assign rxAvail   = not_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags. A status read clears them, but an event landing in
  // the same cycle as the read must survive, so the set term wins.
  // --------------------------------------------------------------------------
  logic overrun;
  logic frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (stat_rd) begin
      overrun   <= ovr_set;
      frame_err <= ferr_set;
    end else begin
      overrun   <= overrun   | ovr_set;
      frame_err <= frame_err | ferr_set;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read data
  // --------------------------------------------------------------------------
  logic [31:0] status_word;

  always_comb begin
    status_word    = 32'(count) << 8;
    status_word[0] = not_empty;
    status_word[1] = overrun;
    status_word[2] = frame_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdData <= '0;
    end else if (stat_rd) begin
      rdData <= status_word;
    end else if (data_rd && not_empty) begin
      rdData <= {24'd0, mem[rd_ptr]};
    end else begin
      rdData <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_mmio
//  Purpose  : Self-checking bench for uart_rx_mmio: directed scenarios plus
//             random frame bursts compared against a queue-based model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_uart_rx_mmio;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF4;
  localparam logic [31:0] DADDR = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        rdEn;
  logic [31:0] rdAddr;
  logic [31:0] rdData;
  logic        rxAvail;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic avail_q = 1'b0;
  logic [31:0] coincide_data;

  // Reference model: received bytes and sticky flags.
  logic [7:0] q[$];
  bit m_ovr = 1'b0;
  bit m_ferr = 1'b0;

  uart_rx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .rdEn   (rdEn),
    .rdAddr (rdAddr),
    .rdData (rdData),
    .rxAvail(rxAvail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxAvail && !avail_q && rise_cyc < 0) rise_cyc <= cyc;
    avail_q <= rxAvail;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rdEn = 1'b1;
    rdAddr = a;
    @(negedge clk);
    rdEn = 1'b0;
    rdAddr = '0;
    d = rdData;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(b);
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = 32'(q.size()) << 8;
    e[0] = (q.size() != 0);
    e[1] = m_ovr;
    e[2] = m_ferr;
    rd(BASE, d);
    check(tag, d, e);
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = '0;
    if (q.size() != 0) e = {24'd0, q.pop_front()};
    rd(DADDR, d);
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    logic [7:0] b;
    bit ok;

    rst = 1'b1;
    rxd = 1'b1;
    rdEn = 1'b0;
    rdAddr = '0;
    idle(3);
    check("reset_rdData", rdData, 32'd0);
    check("reset_rxAvail", 32'(rxAvail), 32'd0);
    rst = 1'b0;
    idle(4);

    // Single byte 0xA5, latency of rxAvail and register reads
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    check("a5_latency", 32'(rise_cyc >= start_cyc + 144 && rise_cyc - start_cyc <= 156), 32'd1);
    rd(BASE + 32'd8, d);
    check("other_addr_read", d, 32'd0);
    rd(BASE, d);
    check("a5_status", d, 32'h0000_0101);
    idle(1);
    check("rdData_idle_zero", rdData, 32'd0);
    rd(DADDR, d);
    check("a5_data", d, 32'h0000_00A5);
    check("a5_rxAvail_drop", 32'(rxAvail), 32'd0);

    // Short glitch on the line
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    rd(BASE, d);
    check("glitch_status", d, 32'd0);
    check("glitch_rxAvail", 32'(rxAvail), 32'd0);

    // Framing error
    send_frame(8'h3C, 1'b0);
    rd(BASE, d);
    check("ferr_status", d, 32'h0000_0004);
    rd(BASE, d);
    check("ferr_cleared", d, 32'd0);

    // Overrun: nine bytes, no reads
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    rd(BASE, d);
    check("ovr_status", d, 32'h0000_0803);
    for (int i = 1; i <= 8; i++) begin
      rd(DADDR, d);
      check("ovr_drain", d, 32'(i));
    end
    rd(DADDR, d);
    check("empty_read", d, 32'd0);
    rd(BASE, d);
    check("empty_status", d, 32'd0);

    // Full FIFO with a data read coinciding with the push of 0x09
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h09, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rdEn = 1'b1;
        rdAddr = DADDR;
        @(negedge clk);
        rdEn = 1'b0;
        rdAddr = '0;
        coincide_data = rdData;
      end
    join
    check("coincide_pop", coincide_data, 32'h0000_0001);
    rd(BASE, d);
    check("coincide_status", d, 32'h0000_0801);
    for (int i = 2; i <= 9; i++) begin
      rd(DADDR, d);
      check("coincide_drain", d, 32'(i));
    end
    rd(DADDR, d);
    check("coincide_empty", d, 32'd0);

    // Reset during the data bits of 0x55, then a clean 0x66
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      b = 8'h55;
      rxd = b[i];
      idle(CPB);
    end
    rst = 1'b1;
    rxd = 1'b1;
    idle(3);
    check("midrst_rdData", rdData, 32'd0);
    check("midrst_rxAvail", 32'(rxAvail), 32'd0);
    rst = 1'b0;
    idle(2 * CPB);
    rd(BASE, d);
    check("midrst_abandon", d, 32'd0);
    send_frame(8'h66, 1'b1);
    rd(BASE, d);
    check("midrst_status", d, 32'h0000_0101);
    rd(DADDR, d);
    check("midrst_data", d, 32'h0000_0066);

    // Random bursts against the model
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        ok = ($urandom_range(0, 3) != 0);
        send_frame(b, ok);
        model_frame(b, ok);
      end
      chk_status("rand_status");
      while (q.size() != 0) chk_pop("rand_data");
      chk_pop("rand_empty");
      check("rand_rxAvail", 32'(rxAvail), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_mmio.md
UART_RX_MMIO -- requirements
Module: uart_rx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; SHALL be an even value of 4 or more.
REQ-002 Parameter FIFO_DEPTH, default 8: receive FIFO entries; SHALL be a power of two of 2 or more.
REQ-003 Parameter BASE_ADDR, default 32'hFFFF_FFF4: status register address; the data register is at BASE_ADDR+4.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rxd  input  1  asynchronous serial line; idles high; 8N1 frame, LSB first.
REQ-007 rdEn  input  1  read strobe from the core data port.
REQ-008 rdAddr  input  32  read address; compared to the full 32 bits.
REQ-009 rdData  output  32  registered read data.
REQ-010 rxAvail  output  1  high while the FIFO is not empty.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all later logic uses only the synchronized value rxs.
REQ-012 The receive FSM SHALL have exactly four states: IDLE, START, DATA, STOP; one bit counter runs 0..CLKS_PER_BIT-1.
REQ-013 In IDLE, a 1->0 transition on rxs SHALL move the FSM to START and clear the counter.
REQ-014 In START, when the counter reaches CLKS_PER_BIT/2-1 (the mid-bit point):
- rxs=0: go to DATA, clear the counter.
- rxs=1: treat as a glitch; return to IDLE with no flag.
REQ-015 In DATA, rxs SHALL be sampled each time the counter reaches CLKS_PER_BIT-1, shifting LSB first; after the 8th sample go to STOP.
REQ-016 In STOP, at counter CLKS_PER_BIT-1:
- rxs=1: push the byte into the FIFO.
- rxs=0: discard the byte and set sticky frameErr.
- Either case: return to IDLE in the same cycle.
REQ-017 FIFO full, push with no same-cycle pop: the byte SHALL be dropped, FIFO contents unchanged, sticky overrun set.
REQ-018 FIFO full, push with a same-cycle pop: pop SHALL occur first, then push; no overrun; count unchanged.
REQ-019 Status read (rdEn=1, rdAddr=BASE_ADDR) SHALL return next cycle:
- bit0 = notEmpty
- bit1 = overrun
- bit2 = frameErr
- bits[11:8] = FIFO count
- other bits 0
REQ-020 A status read SHALL clear overrun and frameErr after capturing them; an error event in that same cycle SHALL leave its flag set.
REQ-021 Data read (rdEn=1, rdAddr=BASE_ADDR+4) SHALL return {24'b0, head byte} next cycle and pop in the same cycle.
REQ-022 A data read while the FIFO is empty SHALL return 0 and SHALL NOT pop or underflow.
REQ-023 rdEn=0, or any other address: rdData SHALL be 0 the next cycle; FIFO and flags unchanged.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be kept in log2(FIFO_DEPTH)+1 bits.
REQ-025 rxAvail SHALL be driven combinationally from count != 0.

Reset
REQ-026 rst=1 at a clock edge SHALL set:
- FSM to IDLE; bit counter, shift register and FIFO pointers/count to 0.
- overrun and frameErr to 0; rdData to 0; rxAvail to 0.
- Both synchronizer flops to 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no push and no flag; after release, the next falling edge on rxd starts a fresh frame.

Verification
REQ-028 Send 0xA5 with CLKS_PER_BIT=16 -> rxAvail rises within 9.5*16+4 cycles of the rxd falling edge; status reads 0x0000_0101; data read returns 0x0000_00A5; rxAvail then drops to 0.
REQ-029 Pull rxd low for 4 cycles, then high -> FSM returns to IDLE; no push; status reads 0x0000_0000.
REQ-030 Send 0x3C with the stop bit held low -> no push; status reads 0x0000_0004; a second status read returns 0x0000_0000.
REQ-031 Send FIFO_DEPTH+1 bytes 0x01..0x09 with no reads -> status reads 0x0000_0803; data reads return 0x01..0x08 in order; a 9th data read returns 0 and count stays 0.
REQ-032 FIFO full, and a data read coincides with the push cycle of byte 0x09 -> no overrun; count stays 8; final read order is 0x02..0x09.
REQ-033 Assert rst during the DATA state of byte 0x55, then send 0x66 -> only 0x66 is received; status reads 0x0000_0101.
